post_spike_collector: RTL and testbench
=======================================

// Module: post_spike_collector
// PURPOSE
// Downstream of the PE cluster. Accepts post-synaptic spike writes (post_req/post_grant, post_waddr/post_wdata),
// tags each with the current timestep, and buffers them in a FIFO. Forwards them as typed packets over a valid/ready
// link to the next layer. When the scheduler signals finish_sche, it drains the FIFO and then emits one end-of-timestep
// (EOT) packet carrying that timestep's spike count.
// PARAMETERS
// POST_WIDTH   32  width of post_waddr / post_wdata
// ADDR_BITS    16  neuron-address bits kept in the packet (low bits of post_waddr); also the EOT count width
// I_T          8   timestamp width
// FIFO_DEPTH   16  event FIFO entries (power of 2, >=2)
// DROP_ZERO    1   1: accepted writes with post_wdata==0 are consumed but not enqueued or counted
// PORTS
// clk         in   1                   clock
// rst         in   1                   asynchronous, active-low reset
// enable      in   1                   1: collector active; 0: post_grant held low, FSM stays IDLE
// timestamp   in   I_T                 current timestep, sampled at each accepted write
// post_req    in   1                   cluster has a spike write pending
// post_waddr  in   POST_WIDTH          target neuron address
// post_wdata  in   POST_WIDTH signed   spike value
// post_grant  out  1                   write accepted this cycle when post_req && post_grant
// finish_sche in   1                   1-cycle pulse: timestep complete
// pkt_valid   out  1                   packet present on pkt_data
// pkt_ready   in   1                   consumer accepts when pkt_valid && pkt_ready
// pkt_data    out  2+I_T+ADDR_BITS+POST_WIDTH   {type[1:0], ts, addr/count, value}; type 01=SPIKE, 10=EOT
// collect_done out 1                   1-cycle pulse when the EOT packet is accepted
// BEHAVIOUR
// - Reset (rst=0, async): FIFO empty, count=0, FSM=IDLE. post_grant=0, pkt_valid=0, pkt_data=0, collect_done=0.
// - FSM states: IDLE -> RUN (enable=1). RUN -> FLUSH (finish_sche). FLUSH -> EOT (FIFO empty and no packet pending).
//   EOT -> RUN (EOT accepted; collect_done=1 that cycle). Any state -> IDLE if enable=0, except FLUSH/EOT, which complete first.
// - post_grant = (state==RUN) && !fifo_full; combinational from registered state/full.
//   Held low in IDLE, FLUSH and EOT, so next-timestep spikes wait.
// - Accept: enqueue {01, timestamp, post_waddr[ADDR_BITS-1:0], post_wdata}; count+1, saturating at 2^ADDR_BITS-1.
//   With DROP_ZERO=1 and wdata==0: grant given, nothing enqueued, no count.
// - Accept coincident with finish_sche in RUN: the spike belongs to the closing timestep.
//   It is enqueued and counted before the EOT.
// - Output stage is a registered slot loaded from the FIFO head. Load latency from accept to pkt_valid = 2 cycles.
//   The slot refills in the same cycle it is consumed: 1 packet/cycle sustained.
// - pkt_valid/pkt_data stay stable until pkt_ready. pkt_valid never drops without a handshake, except on reset.
// - EOT packet: {10, timestamp, count, 0}; count clears to 0 on its acceptance.
// - FIFO full: post_grant=0, no loss. Simultaneous push and pop at full is allowed only when pop frees a slot that cycle.
// - finish_sche outside RUN is ignored. A 2nd finish_sche while in FLUSH/EOT is ignored.
// - Pointers wrap modulo FIFO_DEPTH. full/empty come from an extra pointer bit.
// STRUCTURE
// - snn_pkg: PKT_SPIKE=2'b01, PKT_EOT=2'b10, collector state enum, packet field-offset localparams.
// - Sub-module spike_fifo: sync FIFO, params WIDTH/DEPTH, push/pop/full/empty, async active-low reset.
// - Top: FSM, counter, output slot, grant logic.
// TESTING
// 1 Reset mid-stream: drive 3 spikes, pull rst low for 1 cycle -> pkt_valid=0 next edge; count=0; no stale packet after release.
// 2 Basic: ts=5, spikes addr 0,1,2 with value 2, pkt_ready=1, then finish_sche ->
//   pkts {01,5,0,2},{01,5,1,2},{01,5,2,2},{10,5,3,0}; collect_done pulse.
// 3 Backpressure: pkt_ready=0, 20 writes -> post_grant drops after FIFO_DEPTH+1 accepts.
//   Release ready -> all 17 out in order, none lost.
// 4 Coincident: accept addr 9 in the same cycle as finish_sche -> spike addr 9 precedes EOT; EOT count includes it.
// 5 DROP_ZERO: values 0,7,0 -> one SPIKE (value 7), EOT count=1.
// 6 Ready toggling randomly each cycle with 50 spikes -> pkt_data stable while valid&&!ready; order preserved.

Source files
------------

// File: rtl/snn_pkg.sv
// snn_pkg: packet encoding, collector FSM states and packet field offsets.
package snn_pkg;
  localparam logic [1:0] PKT_SPIKE = 2'b01;
  localparam logic [1:0] PKT_EOT   = 2'b10;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_EOT   = 2'd3;
  localparam int DEF_POST_WIDTH = 32;
  localparam int DEF_ADDR_BITS  = 16;
  localparam int DEF_I_T        = 8;
  // Packet layout {type, ts, addr/count, value}, value at bit 0.
  localparam int PKT_ADDR_LSB = DEF_POST_WIDTH;
  localparam int PKT_TS_LSB   = PKT_ADDR_LSB + DEF_ADDR_BITS;
  localparam int PKT_TYPE_LSB = PKT_TS_LSB + DEF_I_T;
  function automatic int pkt_width(input int post_width, input int addr_bits, input int i_t);
    return 2 + i_t + addr_bits + post_width;
  endfunction
endpackage

// File: rtl/spike_fifo.sv
// spike_fifo: synchronous FIFO; an extra pointer bit separates full from empty.
module spike_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign do_pop = pop && !empty;
  // A push at full is only taken when the same-cycle pop frees a slot.
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/post_spike_collector.sv
// post_spike_collector: buffers timestamped post-synaptic spikes and forwards them as
// SPIKE packets, closing each timestep with an EOT packet carrying its spike count.
module post_spike_collector
  import snn_pkg::*;
#(
  parameter int POST_WIDTH = DEF_POST_WIDTH,
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int I_T        = DEF_I_T,
  parameter int FIFO_DEPTH = 16,
  parameter int DROP_ZERO  = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   enable,
  input  logic [I_T-1:0]                         timestamp,
  input  logic                                   post_req,
  input  logic [POST_WIDTH-1:0]                  post_waddr,
  input  logic signed [POST_WIDTH-1:0]           post_wdata,
  output logic                                   post_grant,
  input  logic                                   finish_sche,
  output logic                                   pkt_valid,
  input  logic                                   pkt_ready,
  output logic [2+I_T+ADDR_BITS+POST_WIDTH-1:0]  pkt_data,
  output logic                                   collect_done
);
  localparam int PW = pkt_width(POST_WIDTH, ADDR_BITS, I_T);
  logic [1:0] state, state_nx;
  logic [ADDR_BITS-1:0] count;
  logic [I_T-1:0] eot_ts;
  logic [PW-1:0] head;
  logic fifo_full, fifo_empty, accept, push, take, pop, eot_load, eot_done;
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, post_waddr[POST_WIDTH-1:ADDR_BITS]};
  assign post_grant = (state == ST_RUN) && !fifo_full;
  assign accept = post_req && post_grant;
  assign push = accept && !((DROP_ZERO != 0) && (post_wdata == '0));
  assign take = !pkt_valid || pkt_ready;
  assign pop = take && !fifo_empty;
  // The EOT slot load waits until every spike of the timestep has left the slot.
  assign eot_load = (state == ST_FLUSH) && fifo_empty && !pkt_valid;
  assign eot_done = (state == ST_EOT) && pkt_valid && pkt_ready;
  assign collect_done = eot_done;
  assign state_nx = (state == ST_IDLE)  ? (enable ? ST_RUN : ST_IDLE) :
                    (state == ST_RUN)   ? (!enable ? ST_IDLE : finish_sche ? ST_FLUSH : ST_RUN) :
                    (state == ST_FLUSH) ? (eot_load ? ST_EOT : ST_FLUSH) :
                    eot_done ? (enable ? ST_RUN : ST_IDLE) : ST_EOT;
  spike_fifo #(
    .WIDTH(PW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .rst_n(rst),
    .push(push),
    .din({PKT_SPIKE, timestamp, post_waddr[ADDR_BITS-1:0], post_wdata}),
    .pop(pop),
    .dout(head),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      count <= '0;
      eot_ts <= '0;
      pkt_valid <= 1'b0;
      pkt_data <= '0;
    end else begin
      state <= state_nx;
      if ((state == ST_RUN) && enable && finish_sche) eot_ts <= timestamp;
      count <= eot_done ? '0 : (push && (count != '1)) ? count + 1'b1 : count;
      if (eot_load) begin
        pkt_valid <= 1'b1;
        pkt_data <= {PKT_EOT, eot_ts, count, {POST_WIDTH{1'b0}}};
      end else if (take) begin
        pkt_valid <= !fifo_empty;
        if (!fifo_empty) pkt_data <= head;
      end
    end
  end
endmodule

// File: tb/tb_post_spike_collector.sv
// tb_post_spike_collector: directed and random stimulus against a packet-queue reference model.
module tb_post_spike_collector;
  localparam int PW = 58;
  logic clk = 1'b0;
  logic rst, enable, post_req, finish_sche, pkt_ready;
  logic [7:0] timestamp;
  logic [31:0] post_waddr;
  logic signed [31:0] post_wdata;
  logic post_grant, pkt_valid, collect_done;
  logic [PW-1:0] pkt_data;
  int checks = 0, failures = 0, acc_cnt = 0, spk_cnt = 0, sent = 0, spk0 = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] hold_d = '0, last_eot = '0, e;
  logic [15:0] cnt = '0;
  logic acc = 1'b0, in_flush = 1'b0, hold_v = 1'b0, rnd_ready = 1'b0;

  post_spike_collector dut (
    .clk(clk), .rst(rst), .enable(enable), .timestamp(timestamp),
    .post_req(post_req), .post_waddr(post_waddr), .post_wdata(post_wdata),
    .post_grant(post_grant), .finish_sche(finish_sche), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .pkt_data(pkt_data), .collect_done(collect_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // One clock: inputs already driven at edge+1; sample at edge+2, update model, advance.
  task automatic cycle();
    if (rnd_ready) pkt_ready = 1'($urandom_range(0, 1));
    #1;
    acc = post_req && post_grant;
    if (hold_v) begin
      chk("hold_valid", 64'(pkt_valid), 64'd1);
      chk("hold_data", 64'(pkt_data), 64'(hold_d));
    end
    hold_v = pkt_valid && !pkt_ready;
    hold_d = pkt_data;
    if (in_flush) chk("grant_in_flush", 64'(post_grant), 64'd0);
    if (pkt_valid && pkt_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pkt", 64'(pkt_valid), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("pkt_data", 64'(pkt_data), 64'(e));
        chk("collect_done", 64'(collect_done), 64'(e[57:56] == 2'b10));
        if (e[57:56] == 2'b10) in_flush = 1'b0;
      end
      if (pkt_data[57:56] == 2'b10) last_eot = pkt_data;
      else spk_cnt++;
    end else chk("collect_done_idle", 64'(collect_done), 64'd0);
    if (acc) begin
      acc_cnt++;
      if (post_wdata != 0) begin
        exp_q.push_back({2'b01, timestamp, post_waddr[15:0], post_wdata});
        cnt = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
      end
    end
    if (finish_sche && enable && !in_flush) begin
      exp_q.push_back({2'b10, timestamp, cnt, 32'd0});
      cnt = '0;
      in_flush = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d);
    post_req = 1'b1;
    post_waddr = a;
    post_wdata = d;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (acc) break;
    end
    chk("send_granted", 64'(acc), 64'd1);
    post_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) cycle();
    chk("drain_done", 64'(exp_q.size()), 64'd0);
    repeat (2) cycle();
  endtask

  task automatic finish();
    finish_sche = 1'b1;
    cycle();
    finish_sche = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; post_req = 1'b0; finish_sche = 1'b0; pkt_ready = 1'b0;
    timestamp = '0; post_waddr = '0; post_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pkt_valid", 64'(pkt_valid), 64'd0);
    chk("rst_pkt_data", 64'(pkt_data), 64'd0);
    chk("rst_grant", 64'(post_grant), 64'd0);
    chk("rst_collect_done", 64'(collect_done), 64'd0);
    rst = 1'b1; post_req = 1'b1; post_waddr = 32'd1; post_wdata = 32'sd1;
    repeat (3) cycle();
    chk("disabled_grant", 64'(post_grant), 64'd0);
    chk("disabled_accepts", 64'(acc_cnt), 64'd0);
    post_req = 1'b0; enable = 1'b1; timestamp = 8'd3;
    // reset in the middle of a stream
    for (int i = 0; i < 3; i++) send(32'(i), 32'd5);
    repeat (2) cycle();
    rst = 1'b0; hold_v = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_pkt_valid", 64'(pkt_valid), 64'd0);
    chk("midrst_grant", 64'(post_grant), 64'd0);
    rst = 1'b1; exp_q.delete(); cnt = '0; in_flush = 1'b0; pkt_ready = 1'b1;
    repeat (8) cycle();
    chk("no_stale_pkt", 64'(pkt_valid), 64'd0);
    // basic timestep
    timestamp = 8'd5;
    for (int i = 0; i < 3; i++) send(32'(i), 32'd2);
    finish();
    chk("basic_eot", 64'(last_eot), 64'({2'b10, 8'd5, 16'd3, 32'd0}));
    // backpressure fills FIFO plus output slot
    timestamp = 8'd7; pkt_ready = 1'b0; acc_cnt = 0;
    post_req = 1'b1; post_waddr = $urandom; post_wdata = $urandom | 32'd1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (acc) begin
        post_waddr = $urandom;
        post_wdata = $urandom | 32'd1;
      end
    end
    chk("bp_accepts", 64'(acc_cnt), 64'd17);
    chk("bp_grant_low", 64'(post_grant), 64'd0);
    post_req = 1'b0; pkt_ready = 1'b1;
    drain();
    finish();
    chk("bp_eot", 64'(last_eot), 64'({2'b10, 8'd7, 16'd17, 32'd0}));
    // spike accepted together with finish_sche, then a second ignored finish
    timestamp = 8'd9;
    send(32'd3, 32'd4);
    send(32'd4, 32'd5);
    post_req = 1'b1; post_waddr = 32'd9; post_wdata = 32'sd11; finish_sche = 1'b1;
    cycle();
    chk("coinc_accept", 64'(acc), 64'd1);
    post_req = 1'b0;
    cycle();
    finish_sche = 1'b0;
    drain();
    chk("coinc_eot", 64'(last_eot), 64'({2'b10, 8'd9, 16'd3, 32'd0}));
    // zero-valued writes are consumed silently
    timestamp = 8'd12; spk0 = spk_cnt;
    send(32'd20, 32'd0);
    send(32'd21, 32'd7);
    send(32'd22, 32'd0);
    finish();
    chk("dz_eot", 64'(last_eot), 64'({2'b10, 8'd12, 16'd1, 32'd0}));
    chk("dz_spikes", 64'(spk_cnt - spk0), 64'd1);
    // random ready and request traffic
    timestamp = 8'd21; rnd_ready = 1'b1; sent = 0;
    for (int i = 0; i < 4000 && sent < 50; i++) begin
      post_req = 1'($urandom_range(0, 1));
      post_waddr = $urandom;
      post_wdata = ($urandom_range(0, 4) == 0) ? 32'sd0 : $urandom;
      cycle();
      if (acc) sent++;
    end
    post_req = 1'b0;
    chk("rand_sent", 64'(sent), 64'd50);
    finish();
    rnd_ready = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
